// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {CLEAR, RUN} rf_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks regs 1..DEPTH-1 writing zero after reset or on
// request, then raises ready. Register 0 is never touched (hardwired zero).
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = addr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          ready,
    output logic          clr_next
);

    // Same width as the counter, so the terminal compare cannot wrap.
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    rf_state_t     state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;

    // Next state: count through CLEAR, re-enter CLEAR on request while running.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_cnt_q == LAST) state_d = RUN;
                else                   clr_cnt_d = clr_cnt_q + AW'(1);
            end
            RUN: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = AW'(1);
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // State register; reset restarts the sweep from register 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= AW'(1);
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign clr_addr = clr_cnt_q;
    assign ready    = (state_q == RUN);
    // Lets the debug register know the post-edge state is CLEAR.
    assign clr_next = rst | (state_d == CLEAR);

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with hardware clear sequencer.
// Optional same-cycle write-to-read bypass under `REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int DATA_W  = DEF_DATA_W,
    parameter  int DEPTH   = DEF_DEPTH,
    parameter  int NUM_RD  = 2,
    parameter  int DBG_IDX = 8,
    localparam int AW      = addr_w(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    input  logic                     we0,
    input  logic [AW-1:0]            wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [AW-1:0]            wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic [NUM_RD*AW-1:0]     ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic                     ready,
    output logic [DATA_W-1:0]        dbg_data
);

    logic          clr_we, clr_next;
    logic [AW-1:0] clr_addr;
    logic          run;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] dbg_q;

    regfile_clear_seq #(.DEPTH(DEPTH)) u_clr (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready),
        .clr_next (clr_next)
    );

    assign run = ready;

    // Array write mux: clear sweep, else the two writeback ports (port 1 wins).
    always_comb begin
        regs_d = regs_q;
        if (clr_we) regs_d[clr_addr] = '0;
        if (run) begin
            if (we0 && (wa0 != '0) && !(we1 && (wa1 == wa0))) regs_d[wa0] = wd0;
            if (we1 && (wa1 != '0))                           regs_d[wa1] = wd1;
        end
    end

    // Array storage; only the clear sweep ever zeroes it.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    // Debug tap tracks the post-edge register value, held at zero in CLEAR.
    always_ff @(posedge clk) begin
        if (rst) dbg_q <= '0;
        else     dbg_q <= clr_next ? '0 : regs_d[DBG_IDX];
    end

    assign dbg_data = dbg_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] val;

        assign addr = ra[i*AW +: AW];

        // Combinational read port; register 0 and the CLEAR state read as zero.
        always_comb begin
            val = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
            if (we1 && (wa1 == addr))      val = wd1;
            else if (we0 && (wa0 == addr)) val = wd0;
`endif
            if (!run || (addr == '0)) val = '0;
        end

        assign rd[i*DATA_W +: DATA_W] = val;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp at default parameters.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst, clr_req, we0, we1;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic        ready;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    regfile_mp dut (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .we0      (we0),
        .wa0      (wa0),
        .wd0      (wd0),
        .we1      (we1),
        .wa1      (wa1),
        .wd1      (wd1),
        .ra       (ra),
        .rd       (rd),
        .ready    (ready),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
        ra = {a1, a0};
        #1;
    endtask

    // 31 edges of clearing; ready must rise exactly on the last one.
    task automatic run_clear(input string tag, input int req_at);
        for (int k = 1; k <= 31; k++) begin
            clr_req = (k == req_at);
            step();
            clr_req = 1'b0;
            check(tag, {31'b0, ready}, {31'b0, (k == 31)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clr_req = 1'b0;
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        ra  = '0;

        // 1. Reset and clear sequence
        step();
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_dbg", dbg_data, 32'd0);
        set_ra(5'd8, 5'd31);
        check("clear_rd0", rd[31:0], 32'd0);
        check("clear_rd1", rd[63:32], 32'd0);
        rst = 1'b0;
        run_clear("clr1_ready", 0);
        for (int a = 0; a < 32; a++) begin
            set_ra(5'(a), 5'(31 - a));
            check("clr1_rd0", rd[31:0], 32'd0);
            check("clr1_rd1", rd[63:32], 32'd0);
        end

        // 2. Dual write, distinct addresses
        we0 = 1'b1; wa0 = 5'd8; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h22;
        step();
        we0 = 1'b0; we1 = 1'b0;
        set_ra(5'd8, 5'd9);
        check("dual_rd8", rd[31:0], 32'h11);
        check("dual_rd9", rd[63:32], 32'h22);
        check("dual_dbg", dbg_data, 32'h11);

        // 3. Write conflict: port 1 wins
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hAAAA;
        we1 = 1'b1; wa1 = 5'd5; wd1 = 32'hBBBB;
        step();
        we0 = 1'b0; we1 = 1'b0;
        set_ra(5'd5, 5'd9);
        check("conflict_rd5", rd[31:0], 32'hBBBB);
        check("conflict_rd9", rd[63:32], 32'h22);

        // 4. Write to register 0 is dropped
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
        set_ra(5'd0, 5'd0);
        check("r0_pre", rd[31:0], 32'd0);
        step();
        we0 = 1'b0;
        set_ra(5'd0, 5'd8);
        check("r0_post", rd[31:0], 32'd0);
        check("r0_rd8", rd[63:32], 32'h11);

        // 6. Bypass / no-bypass with both ports hitting reg 10
        we1 = 1'b1; wa1 = 5'd10; wd1 = 32'h77;
        step();
        we1 = 1'b0;
        we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h66;
        we1 = 1'b1; wa1 = 5'd10; wd1 = 32'h55;
        set_ra(5'd10, 5'd8);
`ifdef REGFILE_BYPASS_EN
        check("bypass_rd10", rd[31:0], 32'h55);
`else
        check("bypass_rd10", rd[31:0], 32'h77);
`endif
        check("bypass_rd8", rd[63:32], 32'h11);
        step();
        we0 = 1'b0; we1 = 1'b0;
        set_ra(5'd10, 5'd0);
        check("bypass_post", rd[31:0], 32'h55);

        // 5. Re-clear; writes during CLEAR dropped, clr_req in CLEAR ignored
        we0 = 1'b1; wa0 = 5'd16; wd0 = 32'h1234;
        step();
        we0 = 1'b0;
        set_ra(5'd16, 5'd8);
        check("reclr_pre16", rd[31:0], 32'h1234);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        check("reclr_ready", {31'b0, ready}, 32'd0);
        check("reclr_dbg", dbg_data, 32'd0);
        check("reclr_rd16", rd[31:0], 32'd0);
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h7;
        run_clear("clr2_ready", 20);
        we0 = 1'b0;
        set_ra(5'd16, 5'd3);
        check("reclr_post16", rd[31:0], 32'd0);
        check("reclr_post3", rd[63:32], 32'd0);
        check("reclr_dbg_post", dbg_data, 32'd0);

        // rst mid-CLEAR restarts the full count
        we0 = 1'b1; wa0 = 5'd8; wd0 = 32'h99;
        step();
        we0 = 1'b0;
        check("mid_dbg99", dbg_data, 32'h99);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("mid_ready", {31'b0, ready}, 32'd0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_dbg", dbg_data, 32'd0);
        run_clear("clr3_ready", 0);
        set_ra(5'd8, 5'd0);
        check("mid_rd8", rd[31:0], 32'd0);
        check("mid_dbg", dbg_data, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
